timer_irq_mmio: RTL
===================

Name: timer_irq_mmio

Overview:
Memory-mapped programmable down-counter timer on the CPU data bus. It decodes memAddr/MemRead/MemWrite and returns memReadData in the same cycle, so the single-cycle core needs no stall. It drives the core's irq input when a timer period expires and the interrupt is enabled. Software clears the interrupt by a write-1-to-clear store to STATUS.

Parameters:
BASE, 32'hFFFF_0000, base byte address of the 16-byte register window; BASE[3:0] must be 0.
PRESCALE, 8'd0, default tick divisor; tick every PRESCALE+1 cycles.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
memAddr  input  32  byte address from core.
memWriteData  input  32  store data.
MemRead  input  1  load strobe.
MemWrite  input  1  store strobe; sampled at rising clk.
memReadData  output  32  load data (combinational); 0 when not selected.
sel  output  1  memAddr[31:4]==BASE[31:4]; the bus mux uses it to pick this block's memReadData.
irq  output  1  interrupt request to core, = PEND & IE (AND of two flops, glitch-free).

Behaviour:
- Register map (offset = memAddr[3:0]):
  - 0x0 CTRL RW: bit0 EN, bit1 AUTO (auto-reload), bit2 IE, others read 0.
  - 0x4 LOAD RW, 32 bits.
  - 0x8 COUNT RW, 32 bits.
  - 0xC STATUS: bit0 PEND (W1C), bit1 RUN (RO).
  - Offsets with memAddr[1:0]!=0 read 0; writes are ignored.
- Reset: CTRL=0, LOAD=0, COUNT=0, PEND=0, prescale counter=0, state IDLE. Outputs sel follows address, memReadData=0, irq=0.
- Reads: memReadData = selected register when sel & MemRead, else 0; zero-latency, no side effects. COUNT reads return the live value.
- Writes: take effect at the rising clk when sel & MemWrite.
- MemRead and MemWrite both high: the write is performed and the read returns the pre-write value.
- Prescaler: 8-bit counter, cleared in IDLE/EXPIRED. In RUN it increments each cycle. tick=1 when counter==divisor, and the counter returns to 0 on that cycle.
- State machine (IDLE, RUN, EXPIRED):
  - IDLE: COUNT holds. CTRL write with EN=1 -> RUN, prescaler cleared.
  - RUN, on tick:
    - COUNT!=0: COUNT<=COUNT-1.
    - COUNT==0: PEND<=1. If AUTO, COUNT<=LOAD and stay in RUN. Else go to EXPIRED and clear EN.
    - Period with AUTO = (LOAD+1)*(divisor+1) cycles. LOAD=0 with AUTO sets PEND every tick.
  - RUN: CTRL write with EN=0 -> IDLE, COUNT frozen.
  - EXPIRED: COUNT=0, RUN bit=0. CTRL write with EN=1 -> RUN; it expires on the next tick unless COUNT was rewritten.
  - STATUS.RUN = (state==RUN).
- Simultaneous events:
  - COUNT write and tick in the same cycle: the write wins, no decrement.
  - STATUS W1C and expiry in the same cycle: the set wins, PEND stays 1.
  - LOAD write and auto-reload in the same cycle: the reload uses the old LOAD; the new LOAD applies to the next period.
  - CTRL write with EN=1 while already in RUN: no prescaler clear, AUTO/IE update only.
- Clearing IE masks irq without clearing PEND; setting IE again re-asserts irq if PEND=1.
- Reset asserted mid-count returns everything to reset values immediately (async) and deasserts irq.

Optional Feature:
TIMER_PRESCALE_EN: when defined, CTRL[15:8] is RW and sets the divisor, reset value PRESCALE; changing it resets the prescale counter. When undefined, CTRL[15:8] reads 0, writes are ignored, and the divisor is fixed at PRESCALE.

Test Plan:
- Reset then read CTRL/LOAD/COUNT/STATUS at BASE+0x0..0xC -> all 0, irq=0; read at BASE+0x10 -> sel=0, memReadData=0.
- PRESCALE=0, write LOAD=3, COUNT=3, CTRL=0x7 (EN|AUTO|IE) -> PEND/irq rise 4 cycles after the CTRL write edge and then every 4 cycles. W1C STATUS=1 -> irq drops next cycle.
- One-shot: COUNT=2, CTRL=0x5 -> expires after 3 ticks, STATUS reads 0x1 (PEND=1, RUN=0), CTRL.EN reads 0, COUNT stays 0.
- Same-cycle W1C with expiry -> PEND remains 1, irq stays high.
- Same-cycle COUNT write 0x10 with a tick -> COUNT reads 0x10 next cycle, not 0x0F.
- With TIMER_PRESCALE_EN, CTRL=0x0301 (divisor 3), COUNT=1 -> expiry 8 cycles after enable. Without the macro, CTRL reads back 0x0001.

Source files
------------

// File: rtl/timer_irq_mmio.sv
// Memory-mapped down-counter timer with a level interrupt cleared by a W1C store to STATUS.
// Define TIMER_PRESCALE_EN to make CTRL[15:8] a writable tick divisor; otherwise the divisor is fixed at PRESCALE.
module timer_irq_mmio #(
  parameter logic [31:0] BASE     = 32'hFFFF_0000,
  parameter logic [7:0]  PRESCALE = 8'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] memReadData,
  output logic        sel,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} TimerState;

  TimerState   state, stateNext;
  logic        en, autoReload, ie, pend;
  logic [31:0] loadReg, countReg;
  logic [7:0]  preCount, divisor, divRead;
  logic        aligned, wrEn, ctrlWr, loadWr, countWr, statusWr;
  logic        tick, zeroHit, expire, divChange;

  assign sel      = (memAddr[31:4] == BASE[31:4]);
  assign aligned  = (memAddr[1:0] == 2'b00);
  assign wrEn     = sel & MemWrite & aligned;
  assign ctrlWr   = wrEn & (memAddr[3:2] == 2'd0);
  assign loadWr   = wrEn & (memAddr[3:2] == 2'd1);
  assign countWr  = wrEn & (memAddr[3:2] == 2'd2);
  assign statusWr = wrEn & (memAddr[3:2] == 2'd3);

  // A tick only happens while running; a zero count on a tick is the end of a period.
  assign tick    = (state == RUN) && (preCount == divisor);
  assign zeroHit = tick && (countReg == 32'd0);
  assign expire  = zeroHit && !autoReload;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] divReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      divReg <= PRESCALE;
    else if (ctrlWr)
      divReg <= memWriteData[15:8];
  end

  assign divisor   = divReg;
  assign divRead   = divReg;
  assign divChange = ctrlWr && (memWriteData[15:8] != divReg);
`else
  assign divisor   = PRESCALE;
  assign divRead   = 8'h00;
  assign divChange = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // A CTRL write outranks a same-cycle expiry so EN and the state never disagree.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (ctrlWr && memWriteData[0]) stateNext = RUN;
      RUN: begin
        if (ctrlWr)
          stateNext = memWriteData[0] ? RUN : IDLE;
        else if (expire)
          stateNext = EXPIRED;
      end
      EXPIRED: if (ctrlWr && memWriteData[0]) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      preCount <= 8'd0;
    else if ((state != RUN) || divChange || tick)
      preCount <= 8'd0;
    else
      preCount <= preCount + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en         <= 1'b0;
      autoReload <= 1'b0;
      ie         <= 1'b0;
      loadReg    <= 32'd0;
    end else begin
      if (ctrlWr) begin
        en         <= memWriteData[0];
        autoReload <= memWriteData[1];
        ie         <= memWriteData[2];
      end else if (expire) begin
        en <= 1'b0;
      end
      if (loadWr)
        loadReg <= memWriteData;
    end
  end

  // Software writes to COUNT beat the tick; the reload reads LOAD before any same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      countReg <= 32'd0;
    else if (countWr)
      countReg <= memWriteData;
    else if (tick) begin
      if (countReg != 32'd0)
        countReg <= countReg - 32'd1;
      else if (autoReload)
        countReg <= loadReg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pend <= 1'b0;
    else if (zeroHit)
      pend <= 1'b1;
    else if (statusWr && memWriteData[0])
      pend <= 1'b0;
  end

  assign irq = pend & ie;

  always_comb begin
    memReadData = 32'd0;
    if (sel && MemRead && aligned) begin
      case (memAddr[3:2])
        2'd0: memReadData = {16'h0000, divRead, 5'b00000, ie, autoReload, en};
        2'd1: memReadData = loadReg;
        2'd2: memReadData = countReg;
        2'd3: memReadData = {30'd0, (state == RUN), pend};
        default: memReadData = 32'd0;
      endcase
    end
  end

endmodule
